// File: rtl/sn74193_gen.sv
`default_nettype none
// ============================================================================
// Module   : sn74193_gen
// Brief    : Parametrised synchronous up/down counter (74192/74193 class).
//            UP/DOWN are sampled as data on CLK_DRV and edge-detected.
//            Optional macro SN74193_GEN_SYNC_EN adds 2-flop input synchronisers.
// Revision : 1.0 - initial release
// ============================================================================
module sn74193_gen #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             CLK_DRV,
  input  logic             RESET,
  input  logic             UP,
  input  logic             DOWN,
  input  logic             CLR,
  input  logic             LOAD_N,
  input  logic [WIDTH-1:0] DATA,
  output logic [WIDTH-1:0] Q,
  output logic             CO_N,
  output logic             BO_N
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

  logic             up_s;
  logic             dn_s;
  logic             clr_s;
  logic             load_n_s;
  logic             up_p_q;
  logic             dn_p_q;
  logic             up_edge;
  logic             dn_edge;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

`ifdef SN74193_GEN_SYNC_EN
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] raw_in;

  assign raw_in = {UP, DOWN, CLR, LOAD_N};

  // Both stages preload the raw input under reset so no edge is fabricated.
  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      sync1_q <= raw_in;
      sync2_q <= raw_in;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign {up_s, dn_s, clr_s, load_n_s} = sync2_q;
`else
  assign up_s     = UP;
  assign dn_s     = DOWN;
  assign clr_s    = CLR;
  assign load_n_s = LOAD_N;
`endif

  assign up_edge = up_s & ~up_p_q;
  assign dn_edge = dn_s & ~dn_p_q;

  always_comb begin
    q_d = q_q;
    if (clr_s) begin
      q_d = '0;
    end else if (!load_n_s) begin
      q_d = DATA;
    end else if (up_edge && dn_s && !dn_edge) begin
      // >= also pulls illegal loaded values back into range
      q_d = (q_q >= C_MAX) ? '0 : q_q + WIDTH'(1);
    end else if (dn_edge && up_s && !up_edge) begin
      q_d = (q_q == '0) ? C_MAX : q_q - WIDTH'(1);
    end
  end

  // Edge history tracks every cycle so held inputs never count late.
  always_ff @(posedge CLK_DRV) begin
    up_p_q <= up_s;
    dn_p_q <= dn_s;
    if (RESET) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q    = q_q;
  assign CO_N = ~(~up_s & (q_q == C_MAX));
  assign BO_N = ~(~dn_s & (q_q == '0));

endmodule
`default_nettype wire

// File: doc/sn74193_gen.md
Name: sn74193_gen

Overview:
- Parametrised synchronous successor of the dual-clock 4-bit up/down counter family (74192/74193 class).
- Configurable width and modulus: binary or decade mode, or any modulus ≤ 2^WIDTH.
- Runs entirely on the fast drive clock. UP and DOWN are treated as data, and their rising edges are detected.
- Drop-in counter for discrete-logic arcade reconstructions: score, timer and position counters. Cascadable through CO_N/BO_N.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MODULUS, 2**WIDTH, count range 0..MODULUS-1 (2..2**WIDTH). Use 10 for 74192 decade behaviour.

Ports:
- CLK_DRV  input  1  drive clock; all state is updated on its rising edge.
- RESET  input  1  synchronous active-high reset.
- UP  input  1  count-up clock; counts on its rising edge, treated as data.
- DOWN  input  1  count-down clock; counts on its rising edge, treated as data.
- CLR  input  1  clear, active-high, level-sensitive.
- LOAD_N  input  1  parallel load, active-low, level-sensitive.
- DATA  input  WIDTH  parallel load value.
- Q  output  WIDTH  counter value, registered.
- CO_N  output  1  carry out, active-low.
- BO_N  output  1  borrow out, active-low.

Behaviour:
- Reset and clocking: one clock, CLK_DRV. Reset is synchronous and active-high (RESET).
- Internal signals:
  - UP_S and DOWN_S are the sampled inputs. They are UP/DOWN directly, or synchronised versions when the optional feature is enabled.
  - UP_P and DOWN_P are registered copies of UP_S/DOWN_S from the previous cycle.
  - up_edge = UP_S & ~UP_P; dn_edge = DOWN_S & ~DOWN_P.
- RESET high, per rising edge:
  - Q <= 0.
  - UP_P <= UP_S and DOWN_P <= DOWN_S, so no spurious edge is seen after reset.
  - Synchroniser flops, if present, load the raw input.
- Priority per CLK_DRV edge: RESET > CLR > load > count > hold.
- CLR high: Q <= 0. Edges occurring while CLR is high are discarded.
- LOAD_N low (CLR low): Q <= DATA every cycle, and edges are discarded.
  - The load is stored unmodified even if DATA ≥ MODULUS.
  - Q follows DATA changes while LOAD_N is held low.
- Count up: up_edge & DOWN_S & ~dn_edge.
  - If Q ≥ MODULUS-1, Q <= 0 (wrap; also recovers from illegal loaded states).
  - Otherwise Q <= Q+1.
- Count down: dn_edge & UP_S & ~up_edge.
  - If Q == 0, Q <= MODULUS-1.
  - Otherwise Q <= Q-1, including from illegal states ≥ MODULUS.
- Ignored edges:
  - An up_edge while DOWN_S is low is ignored; so is a dn_edge while UP_S is low (original gating).
  - Simultaneous up_edge and dn_edge in the same cycle: Q holds.
- Edge tracking: UP_P/DOWN_P update every cycle regardless of CLR/LOAD_N. A held-high input therefore never produces a delayed count once CLR/load is released.
- Latency:
  - Without the optional feature: Q changes on the first CLK_DRV edge at which the raised UP/DOWN is sampled. Q is visible one cycle after the input rises.
  - The minimum UP/DOWN high and low time is 1 CLK_DRV cycle each.
- CO_N and BO_N are combinational from the registered Q and UP_S/DOWN_S:
  - CO_N = ~(~UP_S & (Q == MODULUS-1)).
  - BO_N = ~(~DOWN_S & (Q == 0)).
  - They pulse low for the low phase of the respective count clock, matching original cascade timing. The next stage's UP/DOWN is driven from them.
- Reset values: Q = 0; CO_N = 1 and BO_N = 1 as long as UP_S/DOWN_S are high. Otherwise CO_N/BO_N follow the equations above.
- Width rule: all compares are done at WIDTH bits. MODULUS-1 is truncated to WIDTH bits, and MODULUS = 2**WIDTH gives natural binary wrap.

Optional Feature:
- Macro: SN74193_GEN_SYNC_EN.
- When defined:
  - UP, DOWN, CLR and LOAD_N each pass through a 2-flop synchroniser before use. They can then be asynchronous to CLK_DRV.
  - Count, clear and load latency increase by 2 cycles.
  - CO_N/BO_N use the synchronised UP_S/DOWN_S.
- When undefined: UP_S = UP, DOWN_S = DOWN, and CLR/LOAD_N are used directly. Inputs must be synchronous to CLK_DRV.

Test Plan:
1. Binary wrap: WIDTH=4 default, DOWN=1, RESET then 16 UP pulses (1 cycle low / 1 high) -> Q steps 1..15 then 0. CO_N is low during the UP low phase while Q=15.
2. Decade down: MODULUS=10, UP=1, Q=0, 1 DOWN pulse -> Q=9. BO_N was low during the DOWN low phase at Q=0. A further 3 pulses -> Q=6.
3. Illegal load: MODULUS=10, LOAD_N low with DATA=13 for 1 cycle -> Q=13. Then 1 UP pulse -> Q=0. Reload 13, then 1 DOWN pulse -> Q=12.
4. Priority: CLR=1 and LOAD_N=0 with DATA=5 while UP rises -> Q=0. CLR released with LOAD_N still 0 -> Q=5. LOAD_N released with UP still high -> no count.
5. Simultaneous edges and gating: UP and DOWN rise in the same cycle from 0 -> Q unchanged. An UP rise while DOWN=0 -> Q unchanged.
6. Reset mid-operation: RESET asserted in the same cycle as an up_edge with Q=7 -> Q=0 next cycle. Release RESET with UP held high -> no spurious count. With SN74193_GEN_SYNC_EN defined, an UP rise yields a Q change 3 cycles later.
